muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the ALU in the EX stage of the pipelined core; the hazard unit treats `busy` as a stall source for IF/ID/EX.
- Generalises the single-cycle ALU datapath to multi-cycle signed/unsigned MULT/DIV and MTHI/MTLO.
- Uses a start/busy/done handshake and supports a pipeline flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- BITS_PER_CYCLE, 1, result bits produced per iteration; must divide WIDTH exactly. N = WIDTH/BITS_PER_CYCLE.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 see Optional Feature.
- a  input  WIDTH  rs operand (multiplicand / dividend / move source).
- b  input  WIDTH  rt operand (multiplier / divisor).
- flush  input  1  abort the operation in flight.
- busy  output  1  high in RUN and FIXUP.
- done  output  1  one-cycle pulse when HI/LO are committed.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- div_by_zero  output  1  sticky flag; cleared by the next accepted start.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; internal counter and operand latches cleared.
- States:
  - IDLE: if start=1, flush=0 and op is MULT/MULTU/DIV/DIVU:
    - latch absolute values of a and b (signed ops) or raw values (unsigned ops);
    - latch result signs; counter=0; go to RUN.
  - IDLE, MTHI/MTLO: with start=1, hi<=a (MTHI) or lo<=a (MTLO) at the next edge; busy stays 0; done pulses the following cycle; no state change.
  - RUN: one iteration per cycle (shift-add for multiply, restoring subtract for divide), BITS_PER_CYCLE bits each; counter increments; after N iterations go to FIXUP.
  - FIXUP: apply sign correction; write hi/lo; go to IDLE; done=1 in the next cycle.
- Latency (start sampled at edge 0): busy=1 for cycles 1..N+1; hi/lo updated at edge N+2; done=1 and busy=0 during cycle N+2.
- HI/LO hold their old values until commit; intermediate values are never visible.
- Multiply results:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide results:
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
  - Signed overflow (a = most-negative, b = -1): lo = most-negative, hi = 0, no flag.
- Divide by zero:
  - Same latency as a normal divide.
  - lo = all ones, hi = a.
  - div_by_zero=1 from the commit cycle until the next accepted start.
- Handshake edge cases:
  - start while busy=1 is ignored; the caller must hold start until busy is seen low.
  - start in the cycle done=1 is accepted (state is IDLE).
- flush:
  - In RUN or FIXUP: return to IDLE at the next edge; hi, lo and div_by_zero are not modified; done stays 0.
  - In IDLE: cancels a same-cycle start, including MTHI/MTLO.
  - flush and start in the same cycle: flush wins.
- Reset asserted mid-operation: immediate return to reset values; no commit.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op 110 = MADD (signed), op 111 = MADDU (unsigned).
  - Same latency as MULT.
  - At commit, {hi,lo} <= {hi,lo} + product, modulo 2^(2*WIDTH).
  - flush discards the operation with no accumulation.
- Undefined: op 110/111 with start=1 is ignored; no busy, no done, no state change.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF, start at cycle 0 -> busy cycles 1..33; done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT, a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU, a=0x1234, b=0 -> done at cycle 34; lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; next MULTU start clears the flag.
- MTHI a=0xA5A5A5A5, then MULT 2*3 with flush at cycle 10 -> hi stays 0xA5A5A5A5, done never pulses; a start at cycle 12 is accepted normally.
- MULT, a=5, b=6, with a second start at cycle 5 (ignored) and rst pulsed low at cycle 20 -> hi=lo=0 immediately, busy=0, no done.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Sits beside the ALU in EX; busy stalls IF/ID/EX while an op runs.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, op, a, b     request, opcode, rs/rt operands
//   flush               abort the operation in flight
//   busy, done          busy in RUN/FIXUP, one-cycle commit pulse
//   hi, lo              HI/LO registers
//   div_by_zero         sticky, cleared by the next accepted start
//
// Optional: define MULDIV_MADD_EN to enable MADD (op 110) and
// MADDU (op 111), which accumulate the product into {hi,lo}.
module muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP
    } state_e;

    state_e state_q, state_d;

    // acc: product high half / partial remainder
    // sh:  multiplier shifting out / quotient shifting in
    // opnd: magnitude of multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             madd_q, madd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic op_mult, op_div, op_move, op_madd, op_signed;
    logic idle_req, accept_arith, accept_move, commit;

    // ---------------- decode ----------------
    always_comb begin
        op_mult   = (op == 3'b000) || (op == 3'b001);
        op_div    = (op == 3'b010) || (op == 3'b011);
        op_move   = (op == 3'b100) || (op == 3'b101);
`ifdef MULDIV_MADD_EN
        op_madd   = (op[2:1] == 2'b11);
`else
        op_madd   = 1'b0;
`endif
        // even opcodes are the signed variants
        op_signed = ~op[0];
        idle_req  = (state_q == S_IDLE) && start && !flush;
        accept_arith = idle_req && (op_mult || op_div || op_madd);
        accept_move  = idle_req && op_move;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_arith) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy   = (state_q != S_IDLE);
        commit = (state_q == S_FIXUP) && !flush;
    end

    // ---------------- iteration datapath ----------------
    logic [WIDTH-1:0] acc_n, sh_n;
    logic [WIDTH:0]   rs, sum;
    logic             qb;

    always_comb begin
        acc_n = acc_q;
        sh_n  = sh_q;
        rs    = '0;
        sum   = '0;
        qb    = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_q) begin
                // restoring step; rs < 2*divisor so result fits
                rs = {acc_n, sh_n[WIDTH-1]};
                if (rs >= {1'b0, opnd_q}) begin
                    acc_n = WIDTH'(rs - {1'b0, opnd_q});
                    qb    = 1'b1;
                end else begin
                    acc_n = rs[WIDTH-1:0];
                    qb    = 1'b0;
                end
                sh_n = {sh_n[WIDTH-2:0], qb};
            end else begin
                sum = {1'b0, acc_n}
                    + (sh_n[0] ? {1'b0, opnd_q} : '0);
                acc_n = sum[WIDTH:1];
                sh_n  = {sum[0], sh_n[WIDTH-1:1]};
            end
        end
    end

    // ---------------- sign fixup / commit value ----------------
    logic [2*WIDTH-1:0] prod, prod_s, res;
    logic [WIDTH-1:0]   quo_s, rem_s;

    always_comb begin
        prod   = {acc_q, sh_q};
        prod_s = neg_q ? -prod : prod;
        // divide by zero: quotient all ones, remainder
        // (|a| with dividend sign) reproduces a
        quo_s  = dz_q ? '1 : (neg_q ? -sh_q : sh_q);
        rem_s  = rneg_q ? -acc_q : acc_q;
        res    = is_div_q ? {rem_s, quo_s} : prod_s;
`ifdef MULDIV_MADD_EN
        if (madd_q) begin
            res = {hi_q, lo_q} + prod_s;
        end
`endif
    end

    // ---------------- next-state datapath ----------------
    logic a_neg, b_neg;

    always_comb begin
        acc_d    = acc_q;
        sh_d     = sh_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        madd_d   = madd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = commit || accept_move;

        a_neg = op_signed && a[WIDTH-1];
        b_neg = op_signed && b[WIDTH-1];

        if (accept_arith) begin
            acc_d    = '0;
            sh_d     = a_neg ? -a : a;
            opnd_d   = b_neg ? -b : b;
            cnt_d    = '0;
            is_div_d = op_div;
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = op_div && (b == '0);
            madd_d   = op_madd;
        end else if (state_q == S_RUN) begin
            acc_d = acc_n;
            sh_d  = sh_n;
            cnt_d = cnt_q + 1'b1;
        end

        if (accept_arith || accept_move) begin
            dbz_d = 1'b0;
        end else if (commit && is_div_q && dz_q) begin
            dbz_d = 1'b1;
        end

        if (commit) begin
            {hi_d, lo_d} = res;
        end else if (accept_move) begin
            if (op[0]) begin
                lo_d = a;
            end else begin
                hi_d = a;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            sh_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            madd_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            madd_q   <= madd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
